// File: rtl/resdata_wr_arbiter_pkg.sv
// ============================================================================
// Module : resdata_wr_arbiter_pkg
// Brief  : Shared types and sizing constants for the result-data write arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package resdata_wr_arbiter_pkg;

    localparam int COMPUTING_GROUP_SIZE       = 4;
    localparam int FEATURE_BIT_SIZE           = 8;
    localparam int COMPUTING_UNIT_OUTPUT_SIZE = 4;

    localparam int RESDATA_ARB_NUM_REQ = 4;
    localparam int RESDATA_ARB_IDX_W   = $clog2(RESDATA_ARB_NUM_REQ);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef logic [RESDATA_ARB_IDX_W-1:0] req_idx_t;

endpackage

`default_nettype wire

// File: rtl/resdata_wr_arbiter_rr_picker.sv
// ============================================================================
// Module : rr_picker
// Brief  : Combinational round-robin picker: first valid index at or after ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    logic [IW:0] cand;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            // Candidate index ptr+k, wrapped without a modulo operator.
            cand = {1'b0, ptr_i} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!found_o && valid_i[cand[IW-1:0]]) begin
                found_o = 1'b1;
                idx_o   = cand[IW-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/resdata_wr_arbiter.sv
// ============================================================================
// Module : resdata_wr_arbiter
// Brief  : Round-robin burst arbiter feeding the shared result-data FIFO.
//          Optional counters enabled by RESDATA_ARB_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module resdata_wr_arbiter
    import resdata_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = RESDATA_ARB_NUM_REQ,
    parameter int DATA_WIDTH = COMPUTING_GROUP_SIZE * FEATURE_BIT_SIZE,
    parameter int BURST_LEN  = COMPUTING_UNIT_OUTPUT_SIZE,
    parameter int CNT_WIDTH  = 32,
    localparam int IW        = $clog2(NUM_REQ),
    localparam int BW        = $clog2(BURST_LEN + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    input  logic                          fifo_prog_full,
    input  logic                          fifo_wr_rst_busy,
    output logic [IW-1:0]                 grant_id,
    output logic                          busy,
    output logic [NUM_REQ*CNT_WIDTH-1:0]  perf_words,
    output logic [CNT_WIDTH-1:0]          perf_stall
);

    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [IW-1:0] LAST_REQ  = IW'(NUM_REQ - 1);

    arb_state_t    state_q;
    logic [IW-1:0] grant_q;
    logic [IW-1:0] rr_ptr_q;
    logic [BW-1:0] beat_cnt_q;
    logic          busy_q;

    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic          own_valid;
    logic          own_last;
    logic          own_ready;

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        fifo_din  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IW'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                fifo_din  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        own_ready = (state_q == BURST) && !fifo_full && !fifo_wr_rst_busy;
        req_ready = '0;
        if (own_ready) begin
            req_ready[grant_q] = 1'b1;
        end
        fifo_wr_en = own_valid && own_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // prog_full only gates new grants, never an active burst.
                    if (pick_found && !fifo_prog_full && !fifo_wr_rst_busy) begin
                        state_q    <= BURST;
                        busy_q     <= 1'b1;
                        grant_q    <= pick_idx;
                        beat_cnt_q <= '0;
                    end
                end
                BURST: begin
                    if (fifo_wr_en) begin
                        if (own_last || (beat_cnt_q == LAST_BEAT)) begin
                            state_q  <= IDLE;
                            busy_q   <= 1'b0;
                            rr_ptr_q <= (grant_q == LAST_REQ) ? '0 : grant_q + 1'b1;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_id = grant_q;
    assign busy     = busy_q;

`ifdef RESDATA_ARB_PERF_EN
    logic [CNT_WIDTH-1:0] perf_words_q [NUM_REQ];
    logic [CNT_WIDTH-1:0] perf_stall_q;
    logic                 stall;

    assign stall = (state_q == BURST) && own_valid && !own_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                perf_words_q[i] <= '0;
            end
            perf_stall_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fifo_wr_en && (grant_q == IW'(i)) && (perf_words_q[i] != '1)) begin
                    perf_words_q[i] <= perf_words_q[i] + 1'b1;
                end
            end
            if (stall && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf_out
        assign perf_words[gi*CNT_WIDTH +: CNT_WIDTH] = perf_words_q[gi];
    end
    assign perf_stall = perf_stall_q;
`else
    assign perf_words = '0;
    assign perf_stall = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_resdata_wr_arbiter.sv
// ============================================================================
// Module : tb_resdata_wr_arbiter
// Brief  : Scoreboard bench for resdata_wr_arbiter (honours RESDATA_ARB_PERF_EN).
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_resdata_wr_arbiter;

    localparam int NR    = 4;
    localparam int DW    = 16;
    localparam int BL    = 4;
    localparam int CW    = 32;
    localparam int IW    = $clog2(NR);
    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*DW-1:0] req_data  = '0;
    logic [NR-1:0]    req_last  = '0;
    logic [NR-1:0]    req_ready;
    logic [DW-1:0]    fifo_din;
    logic             fifo_wr_en;
    logic             fifo_full = 1'b0;
    logic             fifo_prog_full = 1'b0;
    logic             fifo_wr_rst_busy = 1'b0;
    logic [IW-1:0]    grant_id;
    logic             busy;
    logic [NR*CW-1:0] perf_words;
    logic [CW-1:0]    perf_stall;

    always #5 clk = ~clk;

    resdata_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_last         (req_last),
        .req_ready        (req_ready),
        .fifo_din         (fifo_din),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_full        (fifo_full),
        .fifo_prog_full   (fifo_prog_full),
        .fifo_wr_rst_busy (fifo_wr_rst_busy),
        .grant_id         (grant_id),
        .busy             (busy),
        .perf_words       (perf_words),
        .perf_stall       (perf_stall)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [DW-1:0] src_data [NR][DEPTH];
    logic        src_last [NR][DEPTH];
    int          src_len [NR];
    int          src_pos [NR];
    logic [NR-1:0] hs = '0;
    int          cyc = 0;
    int          n_hs = 0;
    int          stamp [256];

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: handshake capture and scoreboard compare, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        hs = req_valid & req_ready;
        if (!rst) begin
            exp_q.delete();
        end else if (fifo_wr_en) begin
            if (n_hs < 256) stamp[n_hs] = cyc;
            n_hs++;
            if (exp_q.size() == 0) begin
                check_value("spurious_wr", 64'(fifo_wr_en), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_value("fifo_din", 64'(fifo_din), 64'(e.data));
                check_value("grant_id", 64'(grant_id), 64'(e.id));
                check_value("ready_onehot", 64'(req_ready), 64'(NR'(1) << e.id));
            end
        end
    end

    // Requester models: present the next queued word, advance on handshake.
    always @(posedge clk) begin
        logic [NR-1:0]    v;
        logic [NR-1:0]    l;
        logic [NR*DW-1:0] d;
        #1;
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < NR; i++) begin
            if (hs[i] && rst && (src_pos[i] < src_len[i])) src_pos[i]++;
            if (src_pos[i] < src_len[i]) begin
                v[i]         = 1'b1;
                l[i]         = src_last[i][src_pos[i]];
                d[i*DW +: DW] = src_data[i][src_pos[i]];
            end
        end
        req_valid = v;
        req_last  = l;
        req_data  = d;
    end

    task automatic add_word(input int i, input logic [DW-1:0] d, input logic last);
        src_data[i][src_len[i]] = d;
        src_last[i][src_len[i]] = last;
        src_len[i]++;
    endtask

    task automatic expect_word(input int i, input logic [DW-1:0] d);
        exp_t e;
        e.id   = IW'(i);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int max_cyc);
        int t = 0;
        while (exp_q.size() != 0 && t < max_cyc) begin
            @(negedge clk);
            t++;
        end
        check_value({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_hs(input string tag, input int target, input int max_cyc);
        int t = 0;
        while (n_hs < target && t < max_cyc) begin
            @(negedge clk);
            t++;
        end
        check_value({tag, "_reached"}, 64'(n_hs >= target), 64'd1);
    endtask

    task automatic do_reset();
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) src_len[i] = src_pos[i];
        tick(2);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        // Reset state
        repeat (2) @(negedge clk);
        check_value("rst_busy", 64'(busy), 64'd0);
        check_value("rst_ready", 64'(req_ready), 64'd0);
        check_value("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        check_value("rst_grant", 64'(grant_id), 64'd0);
        check_value("rst_perf_stall", 64'(perf_stall), 64'd0);
        tick(1);
        rst = 1'b1;

        // Single requester, full-length burst without last
        for (int k = 0; k < 4; k++) begin
            add_word(0, DW'(16'h00A0 + k), 1'b0);
            expect_word(0, DW'(16'h00A0 + k));
        end
        wait_drain("single", 40);
        @(negedge clk);
        check_value("single_busy_drop", 64'(busy), 64'd0);
        check_value("single_grant_hold", 64'(grant_id), 64'd0);
        // rr_ptr is now 1: req1 must beat req0
        tick(1);
        add_word(0, 16'h00E1, 1'b1);
        add_word(1, 16'h00E0, 1'b1);
        expect_word(1, 16'h00E0);
        expect_word(0, 16'h00E1);
        wait_drain("rrptr1", 40);

        // All valid, 2-word bursts: order 0,1,2,3,0 with one bubble
        do_reset();
        s = n_hs;
        for (int i = 0; i < NR; i++) begin
            add_word(i, DW'(16'h0B00 + 16 * i), 1'b0);
            add_word(i, DW'(16'h0B01 + 16 * i), 1'b1);
            expect_word(i, DW'(16'h0B00 + 16 * i));
            expect_word(i, DW'(16'h0B01 + 16 * i));
        end
        add_word(0, 16'h0B02, 1'b0);
        add_word(0, 16'h0B03, 1'b1);
        expect_word(0, 16'h0B02);
        expect_word(0, 16'h0B03);
        wait_drain("allvalid", 80);
        for (int k = 1; k < 10; k++) begin
            check_value("burst_gap", 64'(stamp[s+k] - stamp[s+k-1]), (k % 2 == 0) ? 64'd2 : 64'd1);
        end

        // Early last from req2; rr_ptr must become 3
        do_reset();
        add_word(2, 16'h00C0, 1'b0);
        add_word(2, 16'h00C1, 1'b1);
        add_word(2, 16'h00C2, 1'b0);
        add_word(2, 16'h00C3, 1'b1);
        add_word(3, 16'h00D0, 1'b1);
        expect_word(2, 16'h00C0);
        expect_word(2, 16'h00C1);
        expect_word(3, 16'h00D0);
        expect_word(2, 16'h00C2);
        expect_word(2, 16'h00C3);
        wait_drain("early_last", 60);

        // fifo_full for 3 cycles mid-burst
        do_reset();
        s = n_hs;
        for (int k = 0; k < 4; k++) begin
            add_word(1, DW'(16'h00F0 + k), 1'b0);
            expect_word(1, DW'(16'h00F0 + k));
        end
        wait_hs("full_start", s + 1, 40);
        @(posedge clk);
        #1;
        fifo_full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_value("full_ready", 64'(req_ready), 64'd0);
            check_value("full_wr_en", 64'(fifo_wr_en), 64'd0);
            @(posedge clk);
            #1;
        end
        fifo_full = 1'b0;
        wait_drain("full", 40);

        // prog_full while idle blocks the grant
        tick(3);
        fifo_prog_full = 1'b1;
        add_word(1, 16'h0060, 1'b1);
        expect_word(1, 16'h0060);
        repeat (4) begin
            @(negedge clk);
            check_value("pfull_busy", 64'(busy), 64'd0);
        end
        check_value("pfull_pending", 64'(exp_q.size()), 64'd1);
        tick(1);
        fifo_prog_full = 1'b0;
        wait_drain("pfull", 20);

        // Asynchronous reset mid-burst
        tick(2);
        s = n_hs;
        for (int k = 0; k < 4; k++) begin
            add_word(0, DW'(16'h0070 + k), 1'b0);
            expect_word(0, DW'(16'h0070 + k));
        end
        wait_hs("midrst_start", s + 2, 40);
        #2;
        rst = 1'b0;
        for (int i = 0; i < NR; i++) src_len[i] = src_pos[i];
        #1;
        check_value("midrst_busy", 64'(busy), 64'd0);
        check_value("midrst_ready", 64'(req_ready), 64'd0);
        check_value("midrst_wr_en", 64'(fifo_wr_en), 64'd0);
        check_value("midrst_grant", 64'(grant_id), 64'd0);
        check_value("midrst_perf_w0", 64'(perf_words[0 +: CW]), 64'd0);
        tick(2);
        rst = 1'b1;
        add_word(3, 16'h0080, 1'b1);
        expect_word(3, 16'h0080);
        wait_drain("after_rst", 20);

        // Counters: 5 words from req1 plus 2 stall cycles
        do_reset();
        s = n_hs;
        for (int k = 0; k < 5; k++) begin
            add_word(1, DW'(16'h0090 + k), k == 4);
            expect_word(1, DW'(16'h0090 + k));
        end
        wait_hs("perf_start", s + 1, 40);
        @(posedge clk);
        #1;
        fifo_full = 1'b1;
        tick(2);
        fifo_full = 1'b0;
        wait_drain("perf", 40);
        tick(3);
`ifdef RESDATA_ARB_PERF_EN
        check_value("perf_words1", 64'(perf_words[1*CW +: CW]), 64'd5);
        check_value("perf_words0", 64'(perf_words[0 +: CW]), 64'd0);
        check_value("perf_stall", 64'(perf_stall), 64'd2);
`else
        check_value("perf_words1_off", 64'(perf_words[1*CW +: CW]), 64'd0);
        check_value("perf_words0_off", 64'(perf_words[0 +: CW]), 64'd0);
        check_value("perf_stall_off", 64'(perf_stall), 64'd0);
`endif
        check_value("final_idle", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/resdata_wr_arbiter.md
Name: resdata_wr_arbiter

Overview:
- Round-robin write arbiter sharing one result-data FIFO (fifo_resdata) between NUM_REQ computing-group result producers.
- Grants one requester a locked burst of up to BURST_LEN words, or fewer when the requester ends it with last.
- Passes data combinationally to the FIFO write port and applies back-pressure from full, prog_full and wr_rst_busy.
- Sits between the computing-unit output stage and the FIFO.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, COMPUTING_GROUP_SIZE*FEATURE_BIT_SIZE, word width; must equal the FIFO INPUT_WIDTH.
- BURST_LEN, COMPUTING_UNIT_OUTPUT_SIZE, maximum words per grant.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  final word of the requester's burst.
- req_ready  out  NUM_REQ  per-requester accept.
- fifo_din  out  DATA_WIDTH  FIFO write data.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_full  in  1  FIFO full flag.
- fifo_prog_full  in  1  FIFO programmable-full flag.
- fifo_wr_rst_busy  in  1  FIFO reset in progress.
- grant_id  out  $clog2(NUM_REQ)  current or most recent owner.
- busy  out  1  burst in progress.
- perf_words  out  NUM_REQ*CNT_WIDTH  per-requester word counters.
- perf_stall  out  CNT_WIDTH  stall-cycle counter.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0.
  - busy=0, req_ready=0, fifo_wr_en=0, counters=0.
- States:
  - IDLE: arbitrate.
  - BURST: locked to one owner.
- IDLE -> BURST:
  - Requires at least one req_valid, fifo_prog_full=0 and fifo_wr_rst_busy=0.
  - Winner is the first valid requester at or after rr_ptr, searching in increasing index with wrap-around.
  - Winner index is registered into grant_id; beat_cnt=0.
  - No data transfers in the arbitration cycle.
- BURST:
  - req_ready[grant_id] = !fifo_full && !fifo_wr_rst_busy; all other req_ready bits are 0.
  - fifo_wr_en = req_valid[grant_id] & req_ready[grant_id], combinational, zero latency.
  - fifo_din = req_data of grant_id.
  - A handshake increments beat_cnt.
- BURST -> IDLE:
  - Occurs on a handshake where req_last=1 or beat_cnt==BURST_LEN-1.
  - rr_ptr is then set to grant_id+1 modulo NUM_REQ.
- Owner deasserts valid mid-burst: the grant is held and no timeout applies; no other requester is served.
- fifo_full mid-burst: stall with ready low; the word is held by the requester; no loss and no duplicate.
- fifo_prog_full only blocks new grants; it never truncates an active burst.
- fifo_wr_rst_busy during BURST: ready is held low; the burst resumes when the flag clears.
- Simultaneous terminal beat and a new request: return to IDLE; the next grant comes no earlier than the following cycle (one bubble per burst).
- Requests with no grant have no effect; req_ready stays 0.
- busy=1 exactly while state=BURST.
- Reset mid-burst: immediate return to reset values. A partial burst already in the FIFO is not rolled back.

Optional Feature:
- RESDATA_ARB_PERF_EN defined:
  - perf_words[i] increments on each handshake of requester i.
  - perf_stall increments each BURST cycle where the owner is valid but not ready.
  - Both counters saturate at all-ones.
- Undefined: no counter registers; both perf outputs are tied to 0.

Decomposition:
- definitions_pkg gains:
  - typedef arb_state_t {IDLE, BURST}.
  - constant RESDATA_ARB_NUM_REQ.
  - the requester-index typedef.
- Sub-module rr_picker: combinational masked priority encoder taking valid and rr_ptr, returning winner index and found flag; reusable by other arbiters.

Test Plan:
- Single requester: NUM_REQ=4, BURST_LEN=4, req0 sends 4 words 0xA0..0xA3 -> FIFO receives A0..A3 in order; grant_id=0; busy drops after the 4th beat; rr_ptr=1.
- All valid: 2-word bursts each -> grant order 0,1,2,3,0; one idle cycle between bursts; no interleaving within a burst.
- Early last: req2 asserts last on beat 2 with BURST_LEN=4 -> burst ends after 2 words; rr_ptr=3.
- Back-pressure: fifo_full=1 for 3 cycles mid-burst -> req_ready=0 and fifo_wr_en=0 for those cycles; word sequence is intact with no duplicates. With fifo_prog_full=1 while IDLE and req1 valid -> no grant until prog_full=0.
- Reset: assert rst=0 on beat 2 of a burst -> outputs return to reset values asynchronously; after release, req3 alone is granted first.
- With RESDATA_ARB_PERF_EN: 5 words from req1 plus 2 full stall cycles -> perf_words[1]=5, perf_stall=2. Without the macro, both perf outputs are 0.
